ssd_display_mux: RTL
====================

Name: ssd_display_mux

Overview:
- Display back-end fed by the gyro data formatter's 16-bit `frmt` word: four 4-bit digit codes, D1 leftmost.
- Captures a snapshot of `frmt` on each display-update strobe, multiplexes the four digits onto a common-anode 4-digit seven-segment display, and decodes each code to active-low segments.
- Decimal mode adds special glyphs and leading-zero suppression.
- Sits between the data formatter and the board's seven-segment pins.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- frmt  input  16  digit codes {D1,D2,D3,D4}
- display_sel  input  1  1 = decimal/BCD interpretation, 0 = hex interpretation
- dclk  input  1  display-update request, level; snapshot taken on its rising edge
- an  output  4  anodes, active-low; an[3] = D1 (leftmost)
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; constant 1 (off)

Behaviour:
- Reset (rst=0 at clk edge):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Snapshot = 16'h0000, mode reg = 0, dclk_d = 0, cnt = 0, idx = 0.
  - Reset applied mid-slot or mid-capture aborts immediately; no partial state is retained.
- Update capture:
  - dclk_d <= dclk every cycle.
  - When dclk & ~dclk_d, snapshot <= frmt and mode <= display_sel in the same edge.
  - A held-high dclk captures once. Captures are allowed mid-slot; the new value shows at the outputs one cycle later.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt == REFRESH_DIV-1: cnt <= 0 and idx <= idx+1 (2-bit, wraps 3→0).
  - Order of digits: D1, D2, D3, D4.
- Output register:
  - an/seg are registered from the current cnt, idx, snapshot and mode, so latency is 1 cycle.
  - If cnt < BLANK_CYC: an=4'b1111 and seg=7'b1111111.
  - Otherwise an = 4'b0111, 1011, 1101, 1110 for idx 0, 1, 2, 3.
- Hex decode (mode=0): all 16 codes map to glyphs 0-9, A, b, C, d, E, F.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Decimal decode (mode=1):
  - Codes 0-9 use the same glyphs as hex.
  - 4'hA = blank (1111111).
  - 4'hB = 'C' unit glyph (1000110).
  - 4'hF = minus (0111111).
  - 4'hC-4'hE = blank.
- Leading-zero suppression (mode=1 only):
  - D2 is blanked when it is 0.
  - D3 is blanked when it is 0 and D2 is 0.
  - D4 is never suppressed.
  - D1, the sign position, is decoded normally.
- Simultaneous events: a capture on the same edge as a slot wrap is legal. The output on the following cycle uses the new snapshot and the new idx.

Test Plan (REFRESH_DIV=4, BLANK_CYC=1):
- Reset: hold rst=0 for 3 cycles with dclk toggling -> an=1111, seg=1111111, dp=1 throughout. After release, the first lit slot is an=0111 with seg=1000000 (snapshot 0, hex), appearing 2 cycles after release.
- Hex capture: frmt=16'h0A3F, display_sel=0, pulse dclk -> over one 16-cycle frame, lit slots show an=0111/1000000, an=1011/0001000, an=1101/0110000, an=1110/0001110. The first cycle of each slot has an=1111.
- Decimal negative: frmt=16'hF012, display_sel=1 -> D1 minus 0111111; D2 blank; D3 1111001; D4 0100100.
- Decimal positive with zeros: frmt=16'hA000 -> D1, D2, D3 blank; D4 shows 1000000. Temperature frmt=16'hA25B -> blank, 0100100, 0010010, 1000110.
- Held dclk: capture 16'h1234, then hold dclk=1 while frmt changes to 16'h5678 -> display stays 1234. The next rising edge of dclk loads 5678.
- Mid-slot reset: assert rst=0 while cnt=2, idx=2 -> the next cycle shows reset outputs. After release, counting restarts at idx=0, cnt=0 and the snapshot reads 0000.

Source files
------------

// File: rtl/ssd_display_mux.sv
// ssd_display_mux: snapshots the formatter's 4-digit word on each display-update
// strobe and time-multiplexes it onto a common-anode 4-digit seven-segment display.
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   frmt         digit codes {D1,D2,D3,D4}, D1 leftmost
//   display_sel  1 = decimal glyphs + leading-zero suppression, 0 = hex glyphs
//   dclk         update request (level); snapshot taken on its rising edge
//   an           anodes, active-low, an[3] = D1
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low, always off
module ssd_display_mux #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] frmt,
    input  logic        display_sel,
    input  logic        dclk,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_C     = 7'b1000110;

    logic [15:0]      snap_q, snap_d;
    logic             mode_q, mode_d;
    logic             dclk_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic [3:0]       code;
    logic             suppress;

    // Hex glyph table, shared by the decimal digits 0-9.
    function automatic logic [6:0] hex_glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Decimal glyphs: A and C-E blank, B is the degree-C unit, F is the minus sign.
    function automatic logic [6:0] dec_glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'hA, 4'hC, 4'hD, 4'hE: g = SEG_OFF;
            4'hB:                   g = SEG_C;
            4'hF:                   g = SEG_MINUS;
            default:                g = hex_glyph(c);
        endcase
        return g;
    endfunction

    // Current digit and its leading-zero suppression (D1 is the sign, D4 always shown).
    always_comb begin
        code     = snap_q[15:12];
        suppress = 1'b0;
        case (idx_q)
            2'd0: code = snap_q[15:12];
            2'd1: begin
                code     = snap_q[11:8];
                suppress = mode_q && (snap_q[11:8] == 4'h0);
            end
            2'd2: begin
                code     = snap_q[7:4];
                suppress = mode_q && (snap_q[7:4] == 4'h0) && (snap_q[11:8] == 4'h0);
            end
            default: code = snap_q[3:0];
        endcase
    end

    // Next-state: capture, slot counter, registered anode/segment outputs.
    always_comb begin
        snap_d = snap_q;
        mode_d = mode_q;
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        an_d   = 4'b1111;
        seg_d  = SEG_OFF;

        if (dclk && !dclk_q) begin
            snap_d = frmt;
            mode_d = display_sel;
        end

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        if (cnt_q >= BLANK_END) begin
            an_d = ~(4'b1000 >> idx_q);
            if (suppress) begin
                seg_d = SEG_OFF;
            end else if (mode_q) begin
                seg_d = dec_glyph(code);
            end else begin
                seg_d = hex_glyph(code);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_q <= '0;
            mode_q <= 1'b0;
            dclk_q <= 1'b0;
            cnt_q  <= '0;
            idx_q  <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_OFF;
        end else begin
            snap_q <= snap_d;
            mode_q <= mode_d;
            dclk_q <= dclk;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule
